// File: rtl/piso_tx.sv
// piso_tx -- parallel-in, serial-out transmitter.
//
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out LSB
// first, one bit per clock. The next word can be accepted during the last bit,
// so back-to-back words stream with no idle cycle.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   pi        parallel word to transmit
//   pi_valid  pi is valid
//   pi_ready  a word can be accepted this cycle (combinational)
//   so        serial data, LSB first
//   so_valid  so carries a word bit
//   so_last   so carries bit WIDTH-1 of the current word
//   busy      a word is being shifted
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             xfer;

    // Ready during the last bit as well as in IDLE, so a new word can be
    // loaded on the same edge that retires the old one.
    assign pi_ready = !rst && ((state == IDLE) || (cnt == LAST));
    assign xfer     = pi_valid && pi_ready;

    // Outputs decode registered state only; no path from the inputs.
    assign busy     = (state == SHIFT);
    assign so       = busy && sreg[0];
    assign so_valid = busy;
    assign so_last  = busy && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sreg  <= pi;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        sreg <= {1'b0, sreg[WIDTH-1:1]};
                        cnt  <= cnt + 1'b1;
                    end else if (xfer) begin
                        sreg <= pi;
                        cnt  <= '0;
                    end else begin
                        // Clearing sreg keeps so at 0 while idle.
                        sreg  <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    sreg  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: WIDTH=4 and WIDTH=8 instances, directed
// vectors with hand-computed bit sequences, plus a small sipo receiver model
// fed from the WIDTH=4 serial output.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pi;
    logic       pi_valid;
    logic       pi_ready, so, so_valid, so_last, busy;

    logic [7:0] pi8;
    logic       pi_valid8;
    logic       pi_ready8, so8, so_valid8, so_last8, busy8;

    logic [3:0] po;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .pi(pi), .pi_valid(pi_valid),
        .pi_ready(pi_ready), .so(so), .so_valid(so_valid),
        .so_last(so_last), .busy(busy)
    );

    piso_tx #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .pi(pi8), .pi_valid(pi_valid8),
        .pi_ready(pi_ready8), .so(so8), .so_valid(so_valid8),
        .so_last(so_last8), .busy(busy8)
    );

    // Receiver model: shifts so in from the top while so_valid is high.
    always @(posedge clk) begin
        if (rst) po <= '0;
        else if (so_valid) po <= {so, po[3:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Checks WIDTH=4 bits of w on so, starting in the first bit cycle.
    task automatic check_word4(input string tag, input logic [3:0] w);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_so"}, so, w[k]);
            chk({tag, "_vld"}, so_valid, 1'b1);
            chk({tag, "_last"}, so_last, (k == 3));
            tick();
        end
    endtask

    initial begin
        logic [7:0] seq8;
        logic [7:0] w8;

        rst = 1'b1; pi = '0; pi_valid = 1'b0; pi8 = '0; pi_valid8 = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_so", {so, so_valid, so_last}, 3'b000);
        chk("rst_ready", pi_ready, 1'b0);
        chk("rst_ready8", pi_ready8, 1'b0);
        rst = 1'b0; #1;
        chk("rel_ready", pi_ready, 1'b1);

        // Single word 4'b1011
        pi = 4'b1011; pi_valid = 1'b1;
        tick();
        pi_valid = 1'b0;
        chk("single_busy", busy, 1'b1);
        chk("single_ready_mid", pi_ready, 1'b0);
        check_word4("single", 4'b1011);
        chk("single_idle", {busy, so_valid}, 2'b00);
        chk("single_ready", pi_ready, 1'b1);
        chk("single_po", po, 4'b1011);

        // Back-to-back 4'hA then 4'h5
        pi = 4'hA; pi_valid = 1'b1;
        tick();
        pi = 4'h5;
        seq8 = 8'b0101_1010; // bits in shift order, index 0 first: 0,1,0,1,1,0,1,0
        for (int i = 0; i < 8; i++) begin
            chk("b2b_so", so, seq8[i]);
            chk("b2b_vld", so_valid, 1'b1);
            chk("b2b_last", so_last, (i % 4 == 3));
            chk("b2b_ready", pi_ready, (i % 4 == 3));
            tick();
            if (i == 3) pi_valid = 1'b0;
        end
        chk("b2b_idle", busy, 1'b0);
        chk("b2b_po", po, 4'h5);

        // Busy ignore: 4'hF held while 4'h3 shifts
        pi = 4'h3; pi_valid = 1'b1;
        tick();
        pi = 4'hF;
        check_word4("ign3", 4'h3);
        pi_valid = 1'b0;
        chk("ign3_po", po, 4'h3);
        check_word4("ignF", 4'hF);
        chk("ignF_po", po, 4'hF);
        chk("ign_idle", busy, 1'b0);

        // Reset mid-word: 4'hC, reset after bit 1, valid 9 during reset ignored
        pi = 4'hC; pi_valid = 1'b1;
        tick();
        pi_valid = 1'b0;
        chk("rmw_b0", so, 1'b0);
        tick();
        chk("rmw_b1", so, 1'b0);
        tick();
        rst = 1'b1; pi = 4'h9; pi_valid = 1'b1; #1;
        chk("rmw_ready_rst", pi_ready, 1'b0);
        tick();
        rst = 1'b0; pi_valid = 1'b0; #1;
        chk("rmw_out", {so, so_valid, busy, so_last}, 4'b0000);
        chk("rmw_ready", pi_ready, 1'b1);
        tick();
        chk("rmw_still_idle", busy, 1'b0);
        pi_valid = 1'b1;
        tick();
        pi_valid = 1'b0;
        check_word4("rmw9", 4'h9);
        chk("rmw9_idle", busy, 1'b0);

        // WIDTH=8: 8'hA5 then 8'h81 to exercise counter wrap
        for (int j = 0; j < 2; j++) begin
            w8 = (j == 0) ? 8'hA5 : 8'h81;
            pi8 = w8; pi_valid8 = 1'b1;
            tick();
            pi_valid8 = 1'b0;
            for (int k = 0; k < 8; k++) begin
                chk("w8_so", so8, w8[k]);
                chk("w8_vld", so_valid8, 1'b1);
                chk("w8_last", so_last8, (k == 7));
                tick();
            end
            chk("w8_idle", {busy8, so_valid8}, 2'b00);
            chk("w8_ready", pi_ready8, 1'b1);
        end

        // Idle stability with pi toggling and pi_valid low
        for (int i = 0; i < 20; i++) begin
            pi = 4'($urandom);
            pi8 = 8'($urandom);
            tick();
            chk("idle4", {so, so_valid, busy}, 3'b000);
            chk("idle8", {so8, so_valid8, busy8}, 3'b000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
